// File: rtl/alu_result_misr.sv
// BIST response compactor for the 4-bit ALU: folds {zero_flag, result} samples into a MISR
// and compares the final signature against a golden value latched at start.
module alu_result_misr #(
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = 8'h1D,
    parameter logic [SIG_W-1:0] SEED  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       num_vec,
    input  logic [SIG_W-1:0] golden,
    input  logic             in_valid,
    input  logic [3:0]       result,
    input  logic             zero_flag,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [7:0]       vec_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       num_vec_q;
    logic [SIG_W-1:0] golden_q;
    logic [7:0]       vec_cnt_nxt;

    // One MISR step: shift left, fold the dropped MSB back through the taps, xor in the sample.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [4:0]       sample);
        logic [SIG_W-1:0] din;
        din      = '0;
        din[4:0] = sample;
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    endfunction

    assign vec_cnt_nxt = vec_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            signature <= SEED;
            vec_cnt   <= 8'd0;
            num_vec_q <= 8'd0;
            golden_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_vec_q <= num_vec;
                        golden_q  <= golden;
                        signature <= SEED;
                        vec_cnt   <= 8'd0;
                        state     <= (num_vec != 8'd0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        signature <= misr_step(signature, {zero_flag, result});
                        vec_cnt   <= vec_cnt_nxt;
                        if (vec_cnt_nxt == num_vec_q) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (signature == golden_q);

endmodule

// File: tb/tb_alu_result_misr.sv
// Randomized self-checking bench for alu_result_misr against a polynomial-arithmetic reference.
module tb_alu_result_misr;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_vec;
    logic [7:0] golden;
    logic       in_valid;
    logic [3:0] result;
    logic       zero_flag;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
    logic [7:0] vec_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the run in progress
    logic [7:0] exp_sig;
    int         exp_cnt;
    int         exp_n;
    logic [7:0] exp_golden;

    alu_result_misr dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_vec   (num_vec),
        .golden    (golden),
        .in_valid  (in_valid),
        .result    (result),
        .zero_flag (zero_flag),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signature as a polynomial over GF(2): multiply by x, reduce mod x^8+x^4+x^3+x^2+1, add sample.
    function automatic logic [7:0] ref_fold(input logic [7:0] s, input logic [4:0] d);
        int t;
        t = int'(s) * 2;
        if (t >= 256) t = t ^ 'h11D;
        return t[7:0] ^ {3'b000, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input logic [7:0] g);
        start   = 1'b1;
        num_vec = n[7:0];
        golden  = g;
        tick();
        start   = 1'b0;
        num_vec = 8'($urandom);
        golden  = 8'($urandom);
        exp_sig = 8'h00;
        exp_cnt = 0;
        exp_n   = n;
        exp_golden = g;
        check("start_sig", signature, 8'h00);
        check("start_cnt", vec_cnt, 0);
        check("start_busy", busy, n != 0);
        check("start_done", done, n == 0);
    endtask

    task automatic feed(input logic [3:0] r, input logic z, input int gaps);
        for (int i = 0; i < gaps; i++) begin
            in_valid  = 1'b0;
            result    = 4'($urandom);
            zero_flag = 1'($urandom);
            tick();
            check("gap_sig", signature, exp_sig);
        end
        in_valid  = 1'b1;
        result    = r;
        zero_flag = z;
        tick();
        in_valid  = 1'b0;
        exp_sig = ref_fold(exp_sig, {z, r});
        exp_cnt++;
        check("sig", signature, exp_sig);
        check("cnt", vec_cnt, exp_cnt);
        check("busy", busy, exp_cnt != exp_n);
        check("done", done, exp_cnt == exp_n);
        check("pass_run", pass, (exp_cnt == exp_n) && (exp_sig == exp_golden));
    endtask

    // Final checks in DONE, including that in_valid no longer disturbs the signature.
    task automatic check_done(input logic exp_pass);
        check("done_flag", done, 1);
        check("done_pass", pass, exp_pass);
        in_valid  = 1'b1;
        result    = 4'($urandom);
        zero_flag = 1'($urandom);
        tick();
        in_valid  = 1'b0;
        check("done_hold_sig", signature, exp_sig);
        check("done_hold_cnt", vec_cnt, exp_cnt);
        check("done_still", done, 1);
    endtask

    initial begin
        logic [4:0] samp [0:15];
        logic [7:0] fin;
        int         n;
        logic [7:0] g;
        logic [7:0] case4 [0:4];
        case4[0] = 8'h10; case4[1] = 8'h30; case4[2] = 8'h70; case4[3] = 8'hF0; case4[4] = 8'hED;

        rst = 1'b1; start = 1'b0; num_vec = 8'd0; golden = 8'd0;
        in_valid = 1'b0; result = 4'd0; zero_flag = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_sig", signature, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cnt", vec_cnt, 0);

        // Single sample, golden 10
        do_start(1, 8'h10);
        feed(4'd0, 1'b1, 0);
        check("c2_sig", signature, 8'h10);
        check_done(1'b1);

        // Two samples, matching and mismatching golden
        do_start(2, 8'h03);
        feed(4'd3, 1'b0, 0);
        check("c3_sig0", signature, 8'h03);
        feed(4'd5, 1'b0, 0);
        check("c3_sig1", signature, 8'h03);
        check_done(1'b1);
        do_start(2, 8'h04);
        feed(4'd3, 1'b0, 1);
        feed(4'd5, 1'b0, 0);
        check_done(1'b0);

        // Polynomial wrap, back-to-back then with gaps
        do_start(5, 8'hED);
        for (int i = 0; i < 5; i++) begin
            feed(4'd0, 1'b1, 0);
            check("c4_sig", signature, case4[i]);
        end
        check_done(1'b1);
        do_start(5, 8'hED);
        for (int i = 0; i < 5; i++) feed(4'd0, 1'b1, i % 3);
        check("c4g_sig", signature, 8'hED);
        check("c4g_cnt", vec_cnt, 5);
        check_done(1'b1);

        // Zero-length run
        do_start(0, 8'h00);
        check("c5_sig", signature, 8'h00);
        check_done(1'b1);

        // start during RUN is ignored
        do_start(3, 8'h00);
        feed(4'd7, 1'b0, 0);
        start = 1'b1; num_vec = 8'd1; golden = 8'hAA;
        tick();
        start = 1'b0;
        check("c5_ign_busy", busy, 1);
        check("c5_ign_cnt", vec_cnt, 1);
        check("c5_ign_sig", signature, exp_sig);
        feed(4'd9, 1'b1, 0);
        feed(4'd2, 1'b0, 0);
        check_done(exp_sig == 8'h00);

        // Reset mid-run abandons it
        do_start(5, 8'hED);
        feed(4'd0, 1'b1, 0);
        feed(4'd0, 1'b1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c6_sig", signature, 8'h00);
        check("c6_busy", busy, 0);
        check("c6_cnt", vec_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; result = 4'($urandom); zero_flag = 1'b1;
            tick();
            check("c6_nodone", done, 0);
            check("c6_idle_sig", signature, 8'h00);
        end
        in_valid = 1'b0;
        do_start(5, 8'hED);
        for (int i = 0; i < 5; i++) begin
            feed(4'd0, 1'b1, 0);
            check("c6_sig_re", signature, case4[i]);
        end
        check_done(1'b1);

        // Randomized runs, each restarting straight from DONE
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 16);
            fin = 8'h00;
            for (int i = 0; i < n; i++) begin
                samp[i] = 5'($urandom);
                fin = ref_fold(fin, samp[i]);
            end
            g = ($urandom_range(0, 1) == 1) ? fin : (fin ^ 8'($urandom_range(1, 255)));
            do_start(n, g);
            for (int i = 0; i < n; i++) feed(samp[i][3:0], samp[i][4], $urandom_range(0, 2));
            check("rnd_final", signature, fin);
            check_done(fin == g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
